// File: rtl/sram_mem_stage.sv
// MEM-stage controller: 32-bit LDR/STR as two halfword accesses to async SRAM.
// Optional address fault check enabled by defining SRAM_ADDR_CHECK_EN.
module sram_mem_stage #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        addr_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [16:0] word_q;
  logic [15:0] st_hi_q;
  logic [15:0] lo_q;
  logic [31:0] off;
  logic        req;
  logic        fault;
  logic        phase_end;

  assign off       = address - ADDR_BASE;
  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == WC);

`ifdef SRAM_ADDR_CHECK_EN
  logic err_q;
  assign fault    = (address < ADDR_BASE) | (address[1:0] != 2'b00) |
                    (off[31:19] != 13'd0);
  assign addr_err = err_q;
`else
  logic unused_off;
  assign unused_off = ^{off[31:19], off[1:0]};
  assign fault      = 1'b0;
  assign addr_err   = 1'b0;
`endif

  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      word_q      <= 17'd0;
      st_hi_q     <= 16'd0;
      lo_q        <= 16'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (req) begin
            wr_q    <= wr_en;
            word_q  <= off[18:2];
            st_hi_q <= st_val[31:16];
            if (fault) begin
              state <= DONE;
`ifdef SRAM_ADDR_CHECK_EN
              err_q <= 1'b1;
`endif
            end else begin
              state      <= LO;
              sram_addr  <= {off[18:2], 1'b0};
              sram_dq_oe <= wr_en;
              sram_we_n  <= ~wr_en;
              if (wr_en) sram_dq_out <= st_val[15:0];
            end
          end
        end
        LO: begin
          if (phase_end) begin
            cnt       <= 4'd0;
            state     <= HI;
            sram_addr <= {word_q, 1'b1};
            if (wr_q) sram_dq_out <= st_hi_q;
            else      lo_q        <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (phase_end) begin
            cnt        <= 4'd0;
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!wr_q) read_data <= {sram_dq_in, lo_q};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef SRAM_ADDR_CHECK_EN
          err_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Scoreboard bench for sram_mem_stage with a behavioural async SRAM.
// Expected SRAM writes and load results are queued at stimulus time.
module tb_sram_mem_stage;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] st_val = 32'd0;
  logic        ready;
  logic [31:0] read_data;
  logic        addr_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];
  logic [33:0] wq [$];
  logic [31:0] rq [$];
  logic [31:0] last_rd = 32'd0;
  int n_chk = 0;
  int n_fail = 0;

  sram_mem_stage #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .st_val(st_val), .ready(ready),
    .read_data(read_data), .addr_err(addr_err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[9:0]];

  always @(posedge clk)
    if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;

  // every cycle with we_n low must match the next queued halfword write
  always @(negedge clk) begin
    if (!sram_we_n) begin
      logic [33:0] e;
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%h dq=%h", sram_addr, sram_dq_out);
      end else begin
        e = wq.pop_front();
        if ({sram_addr, sram_dq_out} !== e || sram_dq_oe !== 1'b1) begin
          n_fail++;
          $display("FAIL sram_write got addr=%h dq=%h oe=%b want addr=%h dq=%h oe=1",
                   sram_addr, sram_dq_out, sram_dq_oe, e[33:16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [17:0] hw(input logic [31:0] a, input logic hi);
    logic [31:0] o;
    o = a - 32'd1024;
    return {o[18:2], hi};
  endfunction

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    int done;
    int exp_done;
    bit flt;
    logic [17:0] la, ha;
    logic [31:0] e;
    flt = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    flt = (a < 32'd1024) || (a[1:0] != 2'b00) || ((a - 32'd1024) >= 32'h80000);
`endif
    exp_done = flt ? 1 : 2 * (W + 1) + 1;
    la = hw(a, 1'b0);
    ha = hw(a, 1'b1);
    if (w && !flt) begin
      for (int i = 0; i <= W; i++) wq.push_back({la, d[15:0]});
      for (int i = 0; i <= W; i++) wq.push_back({ha, d[31:16]});
      shadow[la[9:0]] = d[15:0];
      shadow[ha[9:0]] = d[31:16];
    end
    if (r && !w) begin
      e = flt ? last_rd : {shadow[ha[9:0]], shadow[la[9:0]]};
      rq.push_back(e);
      last_rd = e;
    end
    @(posedge clk); #1;
    rd_en = r; wr_en = w; address = a; st_val = d;
    done = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) begin
        done = k;
        break;
      end
      @(posedge clk); #1;
      if (!hold) begin
        rd_en = 1'b0; wr_en = 1'b0;
        address = 32'hFFFF_FFF0; st_val = 32'h5555_AAAA;
      end
    end
    n_chk++;
    if (done !== exp_done) begin
      n_fail++;
      $display("FAIL latency got %0d want %0d (addr=%h)", done, exp_done, a);
    end
    n_chk++;
    if (addr_err !== flt) begin
      n_fail++;
      $display("FAIL addr_err got %b want %b", addr_err, flt);
    end
    if (r && !w) begin
      e = rq.pop_front();
      n_chk++;
      if (read_data !== e) begin
        n_fail++;
        $display("FAIL read_data got %h want %h", read_data, e);
      end
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({ready, read_data, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n}
        !== {1'b1, 32'd0, 1'b0, 18'd0, 16'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b rd=%h err=%b a=%h dq=%h oe=%b we_n=%b",
               ready, read_data, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n);
    end
  endtask

  task automatic test_store_load;
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
  endtask

  task automatic test_simultaneous;
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b1);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
  endtask

  task automatic test_flush;
    access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    access(1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, 1'b1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1);
  endtask

  task automatic test_addr_fault;
    access(1'b1, 1'b0, 32'd1022, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [17:0] la, ha;
    la = hw(32'd1040, 1'b0);
    ha = hw(32'd1040, 1'b1);
    wq.push_back({la, 16'h2222});
    wq.push_back({la, 16'h2222});
    wq.push_back({ha, 16'h1111});
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; st_val = 32'h1111_2222;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sram_we_n, sram_dq_oe, ready, read_data} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_mid got we_n=%b oe=%b rdy=%b rd=%h want 1 0 1 0",
               sram_we_n, sram_dq_oe, ready, read_data);
    end
    #10 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes got %0d want 0", wq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
      shadow[i] = 16'(i) ^ 16'hA5A5;
    end
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_addr_fault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- Memory-stage controller directly downstream of the execute ALU.
- Consumes the ALU result as a byte address for LDR/STR and the store value from the register file.
- Performs each 32-bit access as two 16-bit accesses to an external 256K x 16 asynchronous SRAM.
- Drives `ready` low while busy so the pipeline freezes until the access completes.

Parameters:
- WAIT_CYCLES, 1: extra clock cycles each halfword phase is held beyond the first (phase length = WAIT_CYCLES+1); legal 0..15.
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request (LDR in MEM stage).
- wr_en  in  1  store request (STR in MEM stage).
- address  in  32  byte address = ALU output.
- st_val  in  32  store data.
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- read_data  out  32  last completed load word.
- addr_err  out  1  address fault flag (see Optional Feature).
- sram_addr  out  18  SRAM halfword address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives SRAM data bus.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (async, rst_n=0): state IDLE, read_data=0, addr_err=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. Reset mid-access abandons the access; no further SRAM writes occur.
- Address mapping: off = address - ADDR_BASE (32-bit wrap). Low phase sram_addr={off[18:2],1'b0}; high phase sram_addr={off[18:2],1'b1}. off[1:0] ignored unless the macro is set.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en|wr_en), combinational.
  - On a request, latch op (write wins if rd_en & wr_en both 1), address, st_val; go to LO next cycle.
- LO: held WAIT_CYCLES+1 cycles via a phase counter.
  - Write: sram_dq_oe=1, sram_dq_out=st_val[15:0], sram_we_n=0.
  - Read: sram_dq_oe=0, sram_we_n=1; on the final cycle of the phase, capture sram_dq_in into the low half of a temp register.
  - Then go to HI.
- HI: same as LO with st_val[31:16] / high half; then go to DONE.
- DONE: one cycle, ready=1, sram_we_n=1, sram_dq_oe=0.
  - Read: read_data = {hi_temp, lo_temp}, updated on entry to DONE and stable until the next load completes.
  - Next state is always IDLE. The pipeline advances on this edge; a new request is therefore seen in IDLE the following cycle.
- Latency: request first seen in IDLE at cycle 0 → ready=0 for cycles 0..2(WAIT_CYCLES+1) → ready=1 at cycle 2(WAIT_CYCLES+1)+1. With WAIT_CYCLES=1, ready is high at cycle 5.
- Inputs are sampled only in IDLE; changes while busy are ignored.
- A request deasserted mid-access (flush) does not abort: the write completes fully and the read updates read_data.
- sram_we_n is never low in IDLE or DONE, so there is no bus contention at operation boundaries.
- No request: stays in IDLE with ready=1 and SRAM outputs idle; sram_addr holds its last value.

Optional Feature:
- Macro SRAM_ADDR_CHECK_EN.
- Defined: in IDLE, a request with address < ADDR_BASE, or address[1:0] != 0, or off >= 2^19 is a fault.
  - Fault: no SRAM access, sram_we_n stays 1; go directly to DONE with addr_err=1 for that DONE cycle; read_data is unchanged.
  - addr_err=0 in all other cycles.
- Not defined: no check; addr_err tied 0; all addresses map as above, with upper off bits dropped.

Test Plan:
- Store: WAIT_CYCLES=1, ADDR_BASE=1024, wr_en=1, address=1028, st_val=0xDEADBEEF → sram_addr=2 for 2 cycles with we_n=0 and dq_out=0xBEEF, then sram_addr=3 for 2 cycles with dq_out=0xDEAD; ready=0 for cycles 0–4, 1 at cycle 5.
- Load: after the store, rd_en=1, address=1028, with an SRAM model → read_data=0xDEADBEEF at cycle 5; sram_we_n=1 and dq_oe=0 throughout.
- Simultaneous request: rd_en=wr_en=1, address=1024, st_val=0x12345678 → write performed (we_n low in both phases); a subsequent load returns 0x12345678.
- Flush mid-access: wr_en=1 for cycle 0 only, address=1032, st_val=0xCAFEF00D → both halves still written; ready returns to 1 at cycle 5.
- Reset mid-access: rst_n=0 asynchronously during the HI phase of a store → same-instant sram_we_n=1, dq_oe=0, ready=1 (IDLE, no request), read_data=0.
- With SRAM_ADDR_CHECK_EN: rd_en=1, address=1022 → ready=0 at cycle 0, ready=1 and addr_err=1 at cycle 1, no SRAM strobes, read_data unchanged. Without the macro, the same stimulus gives addr_err=0 and a normal 5-cycle access.
